// File: rtl/operand_feeder.sv
// operand_feeder
//   Buffers operand bytes in a small FIFO and feeds them, four at a time
//   (A, B, C, X), to a polynomial evaluator. Each operand is strobed with
//   eval_go high for GO_HIGH_CYCLES and then low for GO_LOW_CYCLES. After
//   the fourth operand the block waits for the evaluator result, captures
//   it and pulses res_valid.
//
//   Parameters
//     GO_HIGH_CYCLES  go-high length per operand (1..15)
//     GO_LOW_CYCLES   go-low length after each go-high phase (1..15)
//     FIFO_DEPTH      operand FIFO entries, power of two, >= 2
//
//   Ports
//     Clock, Reset          single clock, synchronous active-high reset
//     in_data/in_valid/in_ready   upstream byte stream (push on valid & ready)
//     eval_data, eval_go    evaluator DataIn / Go
//     eval_result, eval_result_valid   evaluator DataResult / ResultValid
//     res_data, res_valid   captured result and its one-cycle pulse
//     sets_done             completed operand sets (wraps at 256)
//
//   Build option
//     OPERAND_FEEDER_SET_COUNT_EN  when defined, sets_done is a live counter;
//                                  otherwise it is tied to zero.
module operand_feeder #(
    parameter int GO_HIGH_CYCLES = 2,
    parameter int GO_LOW_CYCLES  = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] eval_data,
    output logic       eval_go,
    input  logic [7:0] eval_result,
    input  logic       eval_result_valid,
    output logic [7:0] res_data,
    output logic       res_valid,
    output logic [7:0] sets_done
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  HI_LAST    = 4'(GO_HIGH_CYCLES - 1);
    localparam logic [3:0]  LO_LAST    = 4'(GO_LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_OP  = 2'd0,
        S_GO_HI    = 2'd1,
        S_GO_LO    = 2'd2,
        S_WAIT_RES = 2'd3
    } state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    state_t        state_reg, state_next;
    logic [7:0]    op_reg, op_next;
    logic [1:0]    op_idx_reg, op_idx_next;
    logic [3:0]    phase_reg, phase_next;
    logic [7:0]    res_data_reg, res_data_next;
    logic          res_valid_reg, res_valid_next;
    logic          push;
    logic          pop;
`ifdef OPERAND_FEEDER_SET_COUNT_EN
    logic [7:0]    sets_done_reg, sets_done_next;
`endif

    assign in_ready  = (count_reg != FULL_COUNT);
    assign eval_data = op_reg;
    // Decoded straight from the state register so the strobe cannot glitch.
    assign eval_go   = (state_reg == S_GO_HI);
    assign res_data  = res_data_reg;
    assign res_valid = res_valid_reg;
`ifdef OPERAND_FEEDER_SET_COUNT_EN
    assign sets_done = sets_done_reg;
`else
    assign sets_done = 8'd0;
`endif

    // Operand storage; the read side is captured into op_reg on the pop edge.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= in_data;
        end
    end

    always_comb begin
        push           = in_valid && in_ready;
        pop            = 1'b0;
        state_next     = state_reg;
        op_next        = op_reg;
        op_idx_next    = op_idx_reg;
        phase_next     = phase_reg;
        res_data_next  = res_data_reg;
        res_valid_next = 1'b0;
`ifdef OPERAND_FEEDER_SET_COUNT_EN
        sets_done_next = sets_done_reg;
`endif

        case (state_reg)
            S_WAIT_OP: begin
                // op_idx is held here, so an underrun mid-set just stalls.
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    op_next    = fifo_mem[rd_ptr_reg];
                    phase_next = 4'd0;
                    state_next = S_GO_HI;
                end
            end
            S_GO_HI: begin
                if (phase_reg == HI_LAST) begin
                    phase_next = 4'd0;
                    state_next = S_GO_LO;
                end else begin
                    phase_next = phase_reg + 4'd1;
                end
            end
            S_GO_LO: begin
                if (phase_reg == LO_LAST) begin
                    phase_next  = 4'd0;
                    op_idx_next = op_idx_reg + 2'd1;
                    state_next  = (op_idx_reg == 2'd3) ? S_WAIT_RES : S_WAIT_OP;
                end else begin
                    phase_next = phase_reg + 4'd1;
                end
            end
            S_WAIT_RES: begin
                if (eval_result_valid) begin
                    res_data_next  = eval_result;
                    res_valid_next = 1'b1;
                    op_idx_next    = 2'd0;
                    state_next     = S_WAIT_OP;
`ifdef OPERAND_FEEDER_SET_COUNT_EN
                    sets_done_next = sets_done_reg + 8'd1;
`endif
                end
            end
            default: begin
                state_next = S_WAIT_OP;
            end
        endcase

        wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW + 1)'(1);
            2'b01:   count_next = count_reg - (AW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            state_reg     <= S_WAIT_OP;
            op_reg        <= 8'd0;
            op_idx_reg    <= 2'd0;
            phase_reg     <= 4'd0;
            res_data_reg  <= 8'd0;
            res_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            state_reg     <= state_next;
            op_reg        <= op_next;
            op_idx_reg    <= op_idx_next;
            phase_reg     <= phase_next;
            res_data_reg  <= res_data_next;
            res_valid_reg <= res_valid_next;
        end
    end

`ifdef OPERAND_FEEDER_SET_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sets_done_reg <= 8'd0;
        end else begin
            sets_done_reg <= sets_done_next;
        end
    end
`endif

endmodule
